// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: RISC-V constants, opcode enum and IR field positions shared by fetch, control and decode
package imem_responder_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LUI    = 7'h37,
    OP_AUIPC  = 7'h17,
    OP_JAL    = 7'h6f,
    OP_JALR   = 7'h67,
    OP_BRANCH = 7'h63,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_OP_IMM = 7'h13,
    OP_OP     = 7'h33
  } opcode_e;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  function automatic logic fetch_fault(input logic [31:0] addr, input int depth);
    return addr[1:0] != 2'b00 || addr[31:2] >= 30'(depth);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response bus between the control FSM and the instruction memory
interface imem_responder_if;
  logic        imem_read;
  logic [31:0] pc;
  logic        busy;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        fault;
  modport master (output imem_read, pc, input busy, rdata_valid, rdata, fault);
  modport slave  (input imem_read, pc, output busy, rdata_valid, rdata, fault);
endinterface

// File: rtl/imem_responder_array.sv
// imem_array: word-addressed instruction storage, synchronous write, combinational read
module imem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clock,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [31:0]                    rdata
);
  logic [31:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clock)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder owning the instruction register
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  imem_responder_if.slave        bus,
  input  logic                   load_ir,
  input  logic                   prog_we,
  input  logic [31:0]            prog_addr,
  input  logic [31:0]            prog_data,
  output logic [31:0]            ir,
  output logic [6:0]             opcode,
  output logic [4:0]             rd,
  output logic [2:0]             funct3,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [6:0]             funct7
);
  localparam int AW = $clog2(DEPTH_WORDS);

  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 4096 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("imem_responder: DEPTH_WORDS must be a power of two in 16..4096");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("imem_responder: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, rdata_q, ir_q;
  logic        fault_q;
  logic        accept, capture, cap_fault, unused_ok;
  logic [31:0] cap_addr, mem_word;

  // With zero wait states the capture edge is the acceptance edge, so the live pc is read
  always_comb begin
    accept    = bus.imem_read && state_q != WAIT;
    state_d   = accept ? (WAIT_CYCLES == 0 ? DONE : WAIT) :
                state_q != WAIT ? IDLE :
                cnt_q == 4'd1 ? DONE : WAIT;
    cnt_d     = accept ? 4'(WAIT_CYCLES) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    capture   = state_d == DONE;
    cap_addr  = state_q == WAIT ? addr_q : bus.pc;
    cap_fault = fetch_fault(cap_addr, DEPTH_WORDS);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      ir_q    <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) addr_q <= bus.pc;
      if (capture) begin
        rdata_q <= cap_fault ? NOP_INSTR : mem_word;
        fault_q <= cap_fault;
      end
      if (load_ir) ir_q <= rdata_q;
    end
  end

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock (clock),
    .we    (prog_we),
    .waddr (prog_addr[AW+1:2]),
    .wdata (prog_data),
    .raddr (cap_addr[AW+1:2]),
    .rdata (mem_word)
  );

  assign unused_ok       = ^{prog_addr[31:AW+2], prog_addr[1:0]};
  assign bus.busy        = state_q != IDLE;
  assign bus.rdata_valid = state_q == DONE;
  assign bus.rdata       = rdata_q;
  assign bus.fault       = fault_q;
  assign ir              = ir_q;
  assign opcode          = ir_q[OPCODE_LSB +: 7];
  assign rd              = ir_q[RD_LSB +: 5];
  assign funct3          = ir_q[FUNCT3_LSB +: 3];
  assign rs1             = ir_q[RS1_LSB +: 5];
  assign rs2             = ir_q[RS2_LSB +: 5];
  assign funct7          = ir_q[FUNCT7_LSB +: 7];
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed bench for zero-wait and three-wait responders with a response scoreboard
module tb_imem_responder;
  import imem_responder_pkg::*;

  typedef struct { logic [31:0] data; logic fault; } exp_t;

  logic        clock = 0, reset = 1, load_ir = 0, prog_we = 0;
  logic [31:0] prog_addr = 0, prog_data = 0;
  logic [31:0] ir0, ir3;
  logic [6:0]  op0, op3, f7_0, f7_3;
  logic [4:0]  rd0, rd3, rs1_0, rs1_3, rs2_0, rs2_3;
  logic [2:0]  f3_0, f3_3;
  int          tests = 0, fails = 0;
  exp_t        q0[$], q3[$];
  logic [31:0] mem0 [256];
  logic [31:0] mem3 [16];

  imem_responder_if bus0();
  imem_responder_if bus3();

  imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (
    .clock(clock), .reset(reset), .bus(bus0), .load_ir(load_ir), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .ir(ir0), .opcode(op0), .rd(rd0),
    .funct3(f3_0), .rs1(rs1_0), .rs2(rs2_0), .funct7(f7_0));

  imem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) u3 (
    .clock(clock), .reset(reset), .bus(bus3), .load_ir(load_ir), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .ir(ir3), .opcode(op3), .rd(rd3),
    .funct3(f3_3), .rs1(rs1_3), .rs2(rs2_3), .funct7(f7_3));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  function automatic exp_t exp0(input logic [31:0] pc);
    if (pc[1:0] != 2'b00 || pc[31:2] >= 30'd256) return '{NOP_INSTR, 1'b1};
    return '{mem0[pc[9:2]], 1'b0};
  endfunction

  function automatic exp_t exp3(input logic [31:0] pc);
    if (pc[1:0] != 2'b00 || pc[31:2] >= 30'd16) return '{NOP_INSTR, 1'b1};
    return '{mem3[pc[5:2]], 1'b0};
  endfunction

  task automatic prog(input logic [31:0] addr, input logic [31:0] data);
    prog_we = 1; prog_addr = addr; prog_data = data;
    cyc;
    prog_we = 0;
    mem0[addr[9:2]] = data;
    mem3[addr[5:2]] = data;
  endtask

  task automatic fetch0(input logic [31:0] pc);
    bus0.imem_read = 1; bus0.pc = pc; q0.push_back(exp0(pc));
    cyc;
    bus0.imem_read = 0;
  endtask

  task automatic fetch3(input logic [31:0] pc);
    bus3.imem_read = 1; bus3.pc = pc; q3.push_back(exp3(pc));
    cyc;
    bus3.imem_read = 0;
    for (int i = 0; i < 8 && !bus3.rdata_valid; i++) cyc;
    chk("fetch3_valid_seen", bus3.rdata_valid, 1);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (bus0.rdata_valid) begin
      tests++;
      assert (q0.size() != 0) else begin
        fails++;
        $error("FAIL sb0_spurious observed=valid expected=no_response rdata=%h", bus0.rdata);
      end
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("sb0_rdata", bus0.rdata, e.data);
        chk("sb0_fault", bus0.fault, e.fault);
      end
    end
    if (bus3.rdata_valid) begin
      tests++;
      assert (q3.size() != 0) else begin
        fails++;
        $error("FAIL sb3_spurious observed=valid expected=no_response rdata=%h", bus3.rdata);
      end
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("sb3_rdata", bus3.rdata, e.data);
        chk("sb3_fault", bus3.fault, e.fault);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus0.imem_read = 0; bus0.pc = 0; bus3.imem_read = 0; bus3.pc = 0;
    cyc;
    chk("rst_busy0", bus0.busy, 0);
    chk("rst_valid0", bus0.rdata_valid, 0);
    chk("rst_rdata0", bus0.rdata, 0);
    chk("rst_fault0", bus0.fault, 0);
    chk("rst_ir0", ir0, NOP_INSTR);
    chk("rst_opcode0", op0, 7'h13);
    chk("rst_busy3", bus3.busy, 0);
    chk("rst_ir3", ir3, NOP_INSTR);
    for (int i = 0; i < 16; i++) prog(32'(i * 4), 32'hA500_0000 + 32'(i * 32'h0101));
    prog(32'd16, 32'h0031_0093);
    reset = 0;
    cyc;
    // zero-wait fetch then IR load
    fetch0(32'd16);
    chk("a_valid", bus0.rdata_valid, 1);
    chk("a_busy", bus0.busy, 1);
    load_ir = 1;
    cyc;
    load_ir = 0;
    chk("a_ir", ir0, 32'h0031_0093);
    chk("a_opcode", op0, 7'h13);
    chk("a_rd", rd0, 1);
    chk("a_funct3", f3_0, 0);
    chk("a_rs1", rs1_0, 2);
    chk("a_imm", {f7_0, rs2_0}, 12'h003);
    chk("a_busy_after", bus0.busy, 0);
    chk("a_valid_after", bus0.rdata_valid, 0);
    // three-wait fetch with an ignored mid-wait request
    bus3.imem_read = 1; bus3.pc = 8; q3.push_back(exp3(8));
    cyc;
    bus3.imem_read = 0;
    chk("b_busy_t1", bus3.busy, 1);
    chk("b_valid_t1", bus3.rdata_valid, 0);
    cyc;
    bus3.imem_read = 1; bus3.pc = 12;
    chk("b_busy_t2", bus3.busy, 1);
    chk("b_valid_t2", bus3.rdata_valid, 0);
    cyc;
    bus3.imem_read = 0;
    chk("b_busy_t3", bus3.busy, 1);
    chk("b_valid_t3", bus3.rdata_valid, 0);
    cyc;
    chk("b_busy_t4", bus3.busy, 1);
    chk("b_valid_t4", bus3.rdata_valid, 1);
    chk("b_rdata_t4", bus3.rdata, mem3[2]);
    cyc;
    chk("b_busy_t5", bus3.busy, 0);
    chk("b_valid_t5", bus3.rdata_valid, 0);
    // faults
    fetch0(32'd18);
    chk("c_mis_fault", bus0.fault, 1);
    chk("c_mis_rdata", bus0.rdata, NOP_INSTR);
    cyc;
    chk("c_fault_held", bus0.fault, 1);
    fetch0(32'd1024);
    chk("c_oor_fault", bus0.fault, 1);
    cyc;
    fetch0(32'd8);
    chk("c_fault_clear", bus0.fault, 0);
    cyc;
    fetch3(32'd64);
    chk("c3_oor_fault", bus3.fault, 1);
    chk("c3_oor_rdata", bus3.rdata, NOP_INSTR);
    cyc;
    fetch3(32'd4);
    chk("c3_fault_clear", bus3.fault, 0);
    cyc;
    // back-to-back with imem_read held high
    bus0.imem_read = 1; bus0.pc = 0; q0.push_back(exp0(0));
    cyc;
    chk("d_valid_1", bus0.rdata_valid, 1);
    bus0.pc = 4; q0.push_back(exp0(4));
    cyc;
    chk("d_valid_2", bus0.rdata_valid, 1);
    bus0.pc = 8; q0.push_back(exp0(8));
    cyc;
    chk("d_valid_3", bus0.rdata_valid, 1);
    chk("d_rdata_3", bus0.rdata, mem0[2]);
    bus0.imem_read = 0;
    cyc;
    chk("d_valid_end", bus0.rdata_valid, 0);
    // program write colliding with capture of the same word
    bus0.imem_read = 1; bus0.pc = 20; q0.push_back(exp0(20));
    chk("e_old_word", mem0[5], 32'hA500_0505);
    prog(32'd20, 32'hDEAD_BEEF);
    bus0.imem_read = 0;
    chk("e_old_returned", bus0.rdata, 32'hA500_0505);
    cyc;
    fetch0(32'd20);
    chk("e_new_returned", bus0.rdata, 32'hDEAD_BEEF);
    cyc;
    // asynchronous reset in the middle of a wait
    load_ir = 1;
    cyc;
    load_ir = 0;
    chk("f_ir3_loaded", ir3, mem3[1]);
    bus3.imem_read = 1; bus3.pc = 4; q3.push_back(exp3(4));
    cyc;
    bus3.imem_read = 0;
    cyc;
    chk("f_busy_pre", bus3.busy, 1);
    #2 reset = 1;
    #1;
    q3.delete();
    chk("f_busy_rst", bus3.busy, 0);
    chk("f_valid_rst", bus3.rdata_valid, 0);
    chk("f_rdata_rst", bus3.rdata, 0);
    chk("f_fault_rst", bus3.fault, 0);
    chk("f_ir_rst", ir3, NOP_INSTR);
    cyc(2);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      cyc;
      chk("f_busy_after", bus3.busy, 0);
    end
    chk("q0_drained", q0.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
